// File: rtl/hazard_ctrl.sv
// hazard_ctrl -- hazard and sequencing controller for the five-stage RV32I pipe.
//
// Decides each cycle whether to stall (hold PC + IF/ID, bubble ID/EX), flush
// wrong-path instructions after a taken redirect, or freeze the whole pipe
// while data memory is busy. Priority: freeze > flush > data-hazard stall.
// All control outputs are combinational and act in the cycle they are raised.
//
// Build option: define FORWARDING_EN to enable EX operand forwarding. Then only
// load-use is a stall source. Without it, any RAW on EX/MEM destinations stalls
// and the forwarding selects are tied to 00.
//
// Ports:
//   clk                      rising-edge clock
//   reset                    asynchronous active-low reset
//   id_rs1_i, id_rs2_i       source indices of the instruction in ID
//   id_use_rs1_i/rs2_i       ID instruction actually reads that source
//   ex/mem/wb_rd_i           destination index per stage
//   ex/mem/wb_regwrite_i     stage writes its rd
//   ex_memread_i             EX instruction is a load
//   redirect_i               EX resolved a taken branch/jump
//   mem_busy_i               data memory not ready this cycle
//   hold_pc_o, hold_ifid_o   PC / IF/ID keep their value
//   bubble_idex_o            ID/EX loads a NOP
//   flush_o                  IF/ID and ID/EX load NOPs
//   freeze_o                 every pipeline register holds
//   fwd_a_o, fwd_b_o         EX operand select: 00 regfile, 01 MEM, 10 WB
module hazard_ctrl #(
  parameter int REG_ADDR_W   = 5,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] id_rs1_i,
  input  logic [REG_ADDR_W-1:0] id_rs2_i,
  input  logic                  id_use_rs1_i,
  input  logic                  id_use_rs2_i,
  input  logic [REG_ADDR_W-1:0] ex_rd_i,
  input  logic [REG_ADDR_W-1:0] mem_rd_i,
  input  logic [REG_ADDR_W-1:0] wb_rd_i,
  input  logic                  ex_regwrite_i,
  input  logic                  mem_regwrite_i,
  input  logic                  wb_regwrite_i,
  input  logic                  ex_memread_i,
  input  logic                  redirect_i,
  input  logic                  mem_busy_i,
  output logic                  hold_pc_o,
  output logic                  hold_ifid_o,
  output logic                  bubble_idex_o,
  output logic                  flush_o,
  output logic                  freeze_o,
  output logic [1:0]            fwd_a_o,
  output logic [1:0]            fwd_b_o
);

  typedef enum logic [1:0] {RUN, FLUSH, MEM_WAIT} state_t;

  localparam logic [2:0] FCNT_RELOAD = 3'(FLUSH_CYCLES - 1);

  state_t     state_q, state_d;
  logic [2:0] fcnt_q, fcnt_d;
  logic       freeze, flush, stall, data_hazard;

  // A source conflicts with a destination only if both sides are live and the
  // index is not x0.
  function automatic logic src_hit(input logic [REG_ADDR_W-1:0] src,
                                   input logic                  used,
                                   input logic [REG_ADDR_W-1:0] dst,
                                   input logic                  we);
    return used && we && (src != '0) && (src == dst);
  endfunction

`ifdef FORWARDING_EN
  // With forwarding, only a load in EX cannot be bypassed in time.
  assign data_hazard = ex_memread_i &&
                       (src_hit(id_rs1_i, id_use_rs1_i, ex_rd_i, ex_regwrite_i) ||
                        src_hit(id_rs2_i, id_use_rs2_i, ex_rd_i, ex_regwrite_i));
`else
  // WB is not checked: the regfile writes in the first half-cycle.
  assign data_hazard = src_hit(id_rs1_i, id_use_rs1_i, ex_rd_i,  ex_regwrite_i)  ||
                       src_hit(id_rs2_i, id_use_rs2_i, ex_rd_i,  ex_regwrite_i)  ||
                       src_hit(id_rs1_i, id_use_rs1_i, mem_rd_i, mem_regwrite_i) ||
                       src_hit(id_rs2_i, id_use_rs2_i, mem_rd_i, mem_regwrite_i);
`endif

  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    freeze  = 1'b0;
    flush   = 1'b0;
    stall   = 1'b0;
    case (state_q)
      FLUSH: begin
        if (mem_busy_i) begin
          // fcnt holds: the flush resumes where it left off once memory is ready.
          freeze = 1'b1;
        end else begin
          flush = 1'b1;
          if (redirect_i) begin
            fcnt_d = FCNT_RELOAD;
          end else if (fcnt_q == 3'd1) begin
            state_d = RUN;
            fcnt_d  = 3'd0;
          end else begin
            fcnt_d = fcnt_q - 3'd1;
          end
        end
      end
      // MEM_WAIT behaves exactly like RUN: a busy cycle freezes and stays
      // waiting, a ready cycle is evaluated as a normal RUN cycle (including
      // any redirect that was held during the freeze).
      default: begin
        if (mem_busy_i) begin
          freeze  = 1'b1;
          state_d = MEM_WAIT;
        end else if (redirect_i) begin
          flush = 1'b1;
          if (FLUSH_CYCLES > 1) begin
            state_d = FLUSH;
            fcnt_d  = FCNT_RELOAD;
          end else begin
            state_d = RUN;
          end
        end else begin
          state_d = RUN;
          stall   = data_hazard;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= RUN;
      fcnt_q  <= 3'd0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
    end
  end

  // Outputs are forced low while reset is asserted, independent of the clock.
  assign freeze_o      = reset & freeze;
  assign flush_o       = reset & flush;
  assign hold_pc_o     = reset & stall;
  assign hold_ifid_o   = reset & stall;
  assign bubble_idex_o = reset & stall;

`ifdef FORWARDING_EN
  logic [REG_ADDR_W-1:0] ex_rs1_q, ex_rs2_q;

  function automatic logic [1:0] fwd_sel(input logic [REG_ADDR_W-1:0] rs);
    if ((rs != '0) && mem_regwrite_i && (mem_rd_i == rs)) return 2'b01;
    if ((rs != '0) && wb_regwrite_i && (wb_rd_i == rs))   return 2'b10;
    return 2'b00;
  endfunction

  // Shadow of the ID/EX source fields: follows ID/EX advance, takes the NOP
  // (x0) on bubble or flush, holds on freeze.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ex_rs1_q <= '0;
      ex_rs2_q <= '0;
    end else if (!freeze) begin
      if (stall || flush) begin
        ex_rs1_q <= '0;
        ex_rs2_q <= '0;
      end else begin
        ex_rs1_q <= id_rs1_i;
        ex_rs2_q <= id_rs2_i;
      end
    end
  end

  assign fwd_a_o = fwd_sel(ex_rs1_q);
  assign fwd_b_o = fwd_sel(ex_rs2_q);
`else
  logic unused_fwd_inputs;
  assign unused_fwd_inputs = ^{wb_rd_i, wb_regwrite_i, ex_memread_i};
  assign fwd_a_o = 2'b00;
  assign fwd_b_o = 2'b00;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] id_rs1_i, id_rs2_i, ex_rd_i, mem_rd_i, wb_rd_i;
  logic       id_use_rs1_i, id_use_rs2_i;
  logic       ex_regwrite_i, mem_regwrite_i, wb_regwrite_i, ex_memread_i;
  logic       redirect_i, mem_busy_i;
  logic       hold_pc_o, hold_ifid_o, bubble_idex_o, flush_o, freeze_o;
  logic [1:0] fwd_a_o, fwd_b_o;

  int tests = 0;
  int fails = 0;

  // Observation vector: {freeze, flush, bubble, hold_ifid, hold_pc, fwd_a, fwd_b}
  localparam logic [8:0] IDLE   = 9'b000000000;
  localparam logic [8:0] FRZ    = 9'b100000000;
  localparam logic [8:0] FLS    = 9'b010000000;
  localparam logic [8:0] STL    = 9'b001110000;
  localparam logic [8:0] FA_MEM = 9'b000000100;
  localparam logic [8:0] FA_WB  = 9'b000001000;
  localparam logic [8:0] FB_MEM = 9'b000000001;

  hazard_ctrl dut (
    .clk(clk), .reset(reset),
    .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i),
    .id_use_rs1_i(id_use_rs1_i), .id_use_rs2_i(id_use_rs2_i),
    .ex_rd_i(ex_rd_i), .mem_rd_i(mem_rd_i), .wb_rd_i(wb_rd_i),
    .ex_regwrite_i(ex_regwrite_i), .mem_regwrite_i(mem_regwrite_i),
    .wb_regwrite_i(wb_regwrite_i), .ex_memread_i(ex_memread_i),
    .redirect_i(redirect_i), .mem_busy_i(mem_busy_i),
    .hold_pc_o(hold_pc_o), .hold_ifid_o(hold_ifid_o),
    .bubble_idex_o(bubble_idex_o), .flush_o(flush_o), .freeze_o(freeze_o),
    .fwd_a_o(fwd_a_o), .fwd_b_o(fwd_b_o)
  );

  always #5 clk = ~clk;

  task automatic clr();
    id_rs1_i = 0; id_rs2_i = 0; id_use_rs1_i = 0; id_use_rs2_i = 0;
    ex_rd_i = 0; mem_rd_i = 0; wb_rd_i = 0;
    ex_regwrite_i = 0; mem_regwrite_i = 0; wb_regwrite_i = 0; ex_memread_i = 0;
    redirect_i = 0; mem_busy_i = 0;
  endtask

  task automatic load_use5();
    ex_rd_i = 5; ex_memread_i = 1; ex_regwrite_i = 1;
    id_rs1_i = 5; id_use_rs1_i = 1;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [8:0] exp);
    logic [8:0] obs;
    obs = {freeze_o, flush_o, bubble_idex_o, hold_ifid_o, hold_pc_o, fwd_a_o, fwd_b_o};
    tests++;
    assert (obs === exp)
      $display("[TB] %-22s obs=%b", tag, obs);
    else begin
      fails++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  initial begin
    // Reset asserted with active inputs: outputs must be 0 before any clock.
    reset = 1'b0;
    clr();
    mem_busy_i = 1; redirect_i = 1;
    #2 chk("reset_async_out", IDLE);
    clr();
    cyc(); reset = 1'b1;
    #3 chk("idle_after_reset", IDLE);

    // Freeze beats stall; MEM_WAIT ready cycle evaluates like RUN.
    cyc(); mem_busy_i = 1; load_use5();
    #3 chk("busy_over_stall", FRZ);
    cyc(); mem_busy_i = 0;
    #3 chk("stall_after_busy", STL);
    cyc(); clr();
    #3 chk("busy_release_idle", IDLE);

    // Redirect pulse, FLUSH_CYCLES=2, concurrent load-use suppressed.
    cyc(); redirect_i = 1; load_use5();
    #3 chk("redir_n", FLS);
    cyc(); redirect_i = 0;
    #3 chk("redir_n1_no_stall", FLS);
    cyc(); clr();
    #3 chk("redir_n2", IDLE);

    // Redirect held under 3 busy cycles, then 2 flush cycles.
    cyc(); redirect_i = 1; mem_busy_i = 1;
    #3 chk("busyredir_frz1", FRZ);
    cyc(); #3 chk("busyredir_frz2", FRZ);
    cyc(); #3 chk("busyredir_frz3", FRZ);
    cyc(); mem_busy_i = 0;
    #3 chk("busyredir_fls1", FLS);
    cyc(); redirect_i = 0;
    #3 chk("busyredir_fls2", FLS);
    cyc(); #3 chk("busyredir_done", IDLE);

    // Busy inside FLUSH: counter holds across the freeze.
    cyc(); redirect_i = 1;
    #3 chk("flbusy_fls1", FLS);
    cyc(); redirect_i = 0; mem_busy_i = 1;
    #3 chk("flbusy_frz", FRZ);
    cyc(); mem_busy_i = 0;
    #3 chk("flbusy_fls2", FLS);
    cyc(); #3 chk("flbusy_done", IDLE);

    // Second redirect during FLUSH reloads the counter.
    cyc(); redirect_i = 1;
    #3 chk("reload_fls1", FLS);
    cyc(); #3 chk("reload_fls2", FLS);
    cyc(); redirect_i = 0;
    #3 chk("reload_fls3", FLS);
    cyc(); #3 chk("reload_done", IDLE);

`ifdef FORWARDING_EN
    // Load-use: one stall cycle, then WB forwarding two cycles later.
    cyc(); load_use5();
    #3 chk("fwd_loaduse_stall", STL);
    cyc(); ex_rd_i = 0; ex_memread_i = 0; ex_regwrite_i = 0;
    mem_rd_i = 5; mem_regwrite_i = 1;
    #3 chk("fwd_loaduse_bubble", IDLE);
    cyc(); clr(); wb_rd_i = 5; wb_regwrite_i = 1;
    #3 chk("fwd_loaduse_wb", FA_WB);
    // MEM vs WB priority on x7.
    cyc(); clr(); id_rs1_i = 7;
    #3 chk("fwd_setup_x7", IDLE);
    cyc(); mem_rd_i = 7; mem_regwrite_i = 1; wb_rd_i = 7; wb_regwrite_i = 1;
    #3 chk("fwd_prio_mem", FA_MEM);
    cyc(); mem_regwrite_i = 0; id_rs2_i = 6;
    #3 chk("fwd_prio_wb", FA_WB);
    cyc(); wb_regwrite_i = 0; mem_rd_i = 6; mem_regwrite_i = 1;
    #3 chk("fwd_b_mem", FB_MEM);
    // Load into x0 is not a hazard.
    cyc(); clr(); ex_memread_i = 1; ex_regwrite_i = 1; id_use_rs1_i = 1;
    #3 chk("fwd_x0_no_stall", IDLE);
    cyc(); clr();
    #3 chk("fwd_idle", IDLE);
`else
    // RAW on x3 without forwarding: stalls while in EX and in MEM.
    cyc(); ex_rd_i = 3; ex_regwrite_i = 1; id_rs1_i = 3; id_use_rs1_i = 1;
    #3 chk("nofwd_raw_ex", STL);
    cyc(); ex_rd_i = 0; ex_regwrite_i = 0; mem_rd_i = 3; mem_regwrite_i = 1;
    #3 chk("nofwd_raw_mem", STL);
    cyc(); mem_rd_i = 0; mem_regwrite_i = 0; wb_rd_i = 3; wb_regwrite_i = 1;
    #3 chk("nofwd_raw_wb", IDLE);
    cyc(); clr(); id_rs2_i = 9; id_use_rs2_i = 1; mem_rd_i = 9; mem_regwrite_i = 1;
    #3 chk("nofwd_rs2_mem", STL);
    cyc(); id_use_rs2_i = 0;
    #3 chk("nofwd_rs2_unused", IDLE);
    cyc(); clr(); ex_regwrite_i = 1; id_use_rs1_i = 1;
    #3 chk("nofwd_x0", IDLE);
    cyc(); clr();
`endif

    // Reset asserted in the second flush cycle: immediate effect.
    cyc(); redirect_i = 1;
    #3 chk("rstfl_fls", FLS);
    cyc(); redirect_i = 0;
    #1 reset = 1'b0;
    #1 chk("rstfl_async", IDLE);
    cyc(); reset = 1'b1;
    #3 chk("rstfl_run_after", IDLE);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and sequencing controller for the five-stage RV32I core. Watches register indices and control bits from ID, EX, MEM and WB, plus the EX-stage redirect and the data-memory busy flag. Decides, per cycle, whether to hold PC and IF/ID, inject a bubble into ID/EX, flush the wrong-path instructions, or freeze the whole pipe. Also drives operand-forwarding selects for EX. It replaces the ad-hoc hazard/flush wiring around the decode stage.

## Interface
Parameters:
- REG_ADDR_W, 5, register index width
- FLUSH_CYCLES, 2, cycles of flush after a taken redirect (legal range 1..7)

Ports (reset is asynchronous, active-low):
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous active-low reset
- id_rs1_i, id_rs2_i  input  REG_ADDR_W  source indices of instruction in ID
- id_use_rs1_i, id_use_rs2_i  input  1  ID instruction actually reads rs1/rs2
- ex_rd_i, mem_rd_i, wb_rd_i  input  REG_ADDR_W  destination indices per stage
- ex_regwrite_i, mem_regwrite_i, wb_regwrite_i  input  1  stage writes rd
- ex_memread_i  input  1  EX instruction is a load
- redirect_i  input  1  EX resolved taken branch/jump (pcWriteEnable)
- mem_busy_i  input  1  data memory not ready this cycle
- hold_pc_o  output  1  PC register keeps its value
- hold_ifid_o  output  1  IF/ID keeps its value
- bubble_idex_o  output  1  ID/EX loads a NOP
- flush_o  output  1  IF/ID and ID/EX load NOPs (wrong path)
- freeze_o  output  1  every pipeline register holds
- fwd_a_o, fwd_b_o  output  2  EX operand select: 00 regfile, 01 MEM result, 10 WB result

## Operation
- State machine, states RUN, FLUSH, MEM_WAIT; 3-bit flush counter fcnt.
- Index 0 never matches (x0 is not a hazard source).
- RUN:
  - mem_busy_i=1 -> freeze_o=1 this cycle; next state MEM_WAIT.
  - Else redirect_i=1 -> flush_o=1 this cycle.
    - FLUSH_CYCLES>1: next state FLUSH, fcnt=FLUSH_CYCLES-1.
    - Otherwise stay in RUN.
  - Else data hazard (see Configuration) -> hold_pc_o=hold_ifid_o=bubble_idex_o=1; stay in RUN.
- FLUSH:
  - flush_o=1 and the hazard stall is suppressed.
  - fcnt decrements each cycle; next state RUN when fcnt==1.
  - mem_busy_i=1 -> freeze_o=1, fcnt holds, and the controller stays in FLUSH.
  - A new redirect_i reloads fcnt=FLUSH_CYCLES-1.
- MEM_WAIT:
  - freeze_o=1 while mem_busy_i=1.
  - When mem_busy_i=0: freeze_o=0 and the cycle is evaluated exactly as in RUN, including a redirect held since the freeze began. Next state follows RUN rules.
- Priority: freeze > flush > data-hazard stall.
  - While freeze_o=1, hold_pc_o, hold_ifid_o, bubble_idex_o and flush_o are all 0.
- Forwarding (FORWARDING_EN defined):
  - fwd_a_o=01 if id_rs1 (as seen in EX) matches mem_rd_i with mem_regwrite_i.
  - Else fwd_a_o=10 if it matches wb_rd_i with wb_regwrite_i.
  - Else fwd_a_o=00. fwd_b_o is the same using rs2.
  - The EX-side source indices are registered internally from id_rs*_i. They update when ID/EX advances, load 0 on bubble or flush, and hold on freeze.

## Timing
- All control outputs are combinational from current state, fcnt and inputs; they act in the same cycle.
- State, fcnt and the EX-side source-index registers update on the rising clk edge.
- Reset (asynchronous, mid-operation included): state=RUN, fcnt=0, EX-side indices=0. All outputs 0 while reset=0.
- Load-use stall: exactly 1 cycle with forwarding.
- Redirect penalty: FLUSH_CYCLES cycles of flush_o, starting in the redirect cycle.
- Freeze stretches by exactly the number of mem_busy_i=1 cycles; no extra cycles after busy drops.

## Configuration
- FORWARDING_EN defined:
  - Forwarding active.
  - Data hazard = load-use only: ex_memread_i, ex_regwrite_i, and ex_rd_i matching a used ID source.
- FORWARDING_EN undefined:
  - fwd_a_o=fwd_b_o=00 constant.
  - Data hazard = a used ID source matches ex_rd_i (ex_regwrite_i) or mem_rd_i (mem_regwrite_i).
  - WB matches are not hazards; the regfile writes before it reads.
  - A RAW dependency therefore stalls up to 2 cycles.

## Test plan
- Load-use, forwarding on:
  - Stimulus: lw x5 in EX; ID add uses x5.
  - Response: hold_pc_o, hold_ifid_o, bubble_idex_o =1 for 1 cycle; then fwd_a_o=10 next-next cycle (x5 reaches WB); no stall for ex_rd_i=0.
- Redirect, FLUSH_CYCLES=2:
  - Stimulus: redirect_i pulse in cycle N.
  - Response: flush_o=1 in N and N+1, 0 in N+2; a concurrent load-use match gives no stall.
- Busy during redirect:
  - Stimulus: redirect_i=1 held with mem_busy_i=1 for 3 cycles.
  - Response: freeze_o=1 for 3 cycles with flush_o=0; then flush_o=1 for 2 cycles.
- Forwarding priority:
  - Stimulus: MEM and WB both write x7; EX reads x7.
  - Response: fwd_a_o=01.
  - Stimulus: only WB writes x7.
  - Response: fwd_a_o=10.
- No forwarding (FORWARDING_EN undefined):
  - Stimulus: add x3 in EX; ID sub reads x3.
  - Response: stall 2 cycles; fwd outputs stay 00.
- Reset mid-FLUSH:
  - Stimulus: reset low in cycle N+1 of a flush.
  - Response: flush_o=0 immediately, without waiting for clk; after release, state is RUN and outputs are 0.
